// File: rtl/mem_bank.sv
// Parametrised storage bank with byte-lane writes, registered reads,
// out-of-range detection and a sequential run-time clear sweep.
module mem_bank #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sel,
  input  logic              wr,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  input  logic              clr,
  output logic              busy
);

  localparam int AW1 = AW + 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = AW1'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     ptr_r;
  logic              busy_r;
  logic              ready_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic              err_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              accept_s;
  logic              in_range_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DEPTH-1:0]  wr_hit_s;
  logic [DEPTH-1:0]  clr_hit_s;

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   lane_en
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int k = 0; k < BE_W; k++) begin
      res[8*k +: 8] = lane_en[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
    end
    return res;
  endfunction

  assign accept_s   = sel & ready_r;
  assign in_range_s = ({1'b0, addr} < DEPTH_EXT);

  // Read mux and per-entry write/clear decode; out-of-range addresses hit no entry.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    wr_hit_s  = {DEPTH{1'b0}};
    clr_hit_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      rd_word_s    = (addr == AW'(i)) ? mem_r[i] : rd_word_s;
      wr_hit_s[i]  = accept_s & wr & (addr == AW'(i));
      clr_hit_s[i] = (state_r == CLEAR) & (ptr_r == AW'(i));
    end
  end

  // Storage array: sweep zeroing wins, though accesses are never accepted while sweeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_hit_s[i]) begin
          mem_r[i] <= {DATA_W{1'b0}};
        end else if (wr_hit_s[i]) begin
          mem_r[i] <= merge_lanes(mem_r[i], wdata, be);
        end else begin
          mem_r[i] <= mem_r[i];
        end
      end
    end
  end

  // Response path: read data, valid strobe and range-error strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_r  <= {DATA_W{1'b0}};
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= accept_s & ~wr;
      err_r    <= accept_s & ~in_range_s;
      if (accept_s & ~wr) begin
        rdata_r <= in_range_s ? rd_word_s : {DATA_W{1'b0}};
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Clear sequencer with registered busy/ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      ptr_r   <= {AW{1'b0}};
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (clr) begin
            state_r <= CLEAR;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            state_r <= IDLE;
            ptr_r   <= ptr_r;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_r == LAST_IDX) begin
            state_r <= IDLE;
            ptr_r   <= {AW{1'b0}};
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            state_r <= CLEAR;
            ptr_r   <= ptr_r + AW'(1);
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= {AW{1'b0}};
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign busy   = busy_r;
  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;

endmodule

// File: tb/tb_mem_bank.sv
// Drives a DEPTH=5 and a DEPTH=8 bank from one request stream and compares
// both against an array-level model of the bank's externally visible rules.
module tb_mem_bank;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sel;
  logic        wr;
  logic        clr;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;

  logic        ready_a, rvalid_a, err_a, busy_a;
  logic [15:0] rdata_a;
  logic        ready_b, rvalid_b, err_b, busy_b;
  logic [15:0] rdata_b;

  int          checks;
  int          errors;

  int          depth_m [2] = '{5, 8};
  logic [15:0] mem_m [2][8];
  int          busy_left [2];
  logic [15:0] exp_rdata [2];
  logic        exp_rvalid [2];
  logic        exp_err [2];

  always #5 clk = ~clk;

  mem_bank #(.DATA_W(16), .DEPTH(5)) u_a (
    .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a), .err(err_a), .clr(clr), .busy(busy_a)
  );

  mem_bank #(.DATA_W(16), .DEPTH(8)) u_b (
    .clk(clk), .rstn(rstn), .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .be(be),
    .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .err(err_b), .clr(clr), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 8; i++) mem_m[j][i] = 16'h0000;
      busy_left[j]  = 0;
      exp_rdata[j]  = 16'h0000;
      exp_rvalid[j] = 1'b0;
      exp_err[j]    = 1'b0;
    end
  endtask

  // Effect of one rising edge on each bank, given the currently driven inputs.
  task automatic model_edge();
    for (int j = 0; j < 2; j++) begin
      int   a;
      logic acc;
      logic inr;
      a   = int'(addr);
      acc = sel && (busy_left[j] == 0);
      inr = (a < depth_m[j]);
      exp_rvalid[j] = 1'b0;
      exp_err[j]    = 1'b0;
      if (acc) begin
        exp_err[j] = !inr;
        if (wr) begin
          if (inr) begin
            for (int k = 0; k < 2; k++)
              if (be[k]) mem_m[j][a][8*k +: 8] = wdata[8*k +: 8];
          end
        end else begin
          exp_rvalid[j] = 1'b1;
          exp_rdata[j]  = inr ? mem_m[j][a] : 16'h0000;
        end
      end
      if (busy_left[j] > 0) begin
        busy_left[j]--;
      end else if (clr) begin
        busy_left[j] = depth_m[j];
        for (int i = 0; i < 8; i++) mem_m[j][i] = 16'h0000;
      end
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, " a.rdata"},  {16'h0, rdata_a},  {16'h0, exp_rdata[0]});
    chk({where, " a.rvalid"}, {31'h0, rvalid_a}, {31'h0, exp_rvalid[0]});
    chk({where, " a.err"},    {31'h0, err_a},    {31'h0, exp_err[0]});
    chk({where, " a.busy"},   {31'h0, busy_a},   {31'h0, busy_left[0] > 0});
    chk({where, " a.ready"},  {31'h0, ready_a},  {31'h0, busy_left[0] == 0});
    chk({where, " b.rdata"},  {16'h0, rdata_b},  {16'h0, exp_rdata[1]});
    chk({where, " b.rvalid"}, {31'h0, rvalid_b}, {31'h0, exp_rvalid[1]});
    chk({where, " b.err"},    {31'h0, err_b},    {31'h0, exp_err[1]});
    chk({where, " b.busy"},   {31'h0, busy_b},   {31'h0, busy_left[1] > 0});
    chk({where, " b.ready"},  {31'h0, ready_b},  {31'h0, busy_left[1] == 0});
  endtask

  task automatic cycle(input logic s, input logic w, input logic [2:0] a,
                       input logic [15:0] d, input logic [1:0] b, input logic c,
                       input string tag);
    sel = s; wr = w; addr = a; wdata = d; be = b; clr = c;
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    int busy_cnt;
    checks = 0;
    errors = 0;
    rstn = 1'b0; sel = 1'b0; wr = 1'b0; clr = 1'b0;
    addr = 3'd0; wdata = 16'h0000; be = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rstn = 1'b1;
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, "idle");

    // Reset readback: four consecutive reads.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3'(i), 16'h0000, 2'b00, 1'b0, "readback");

    // Byte enables.
    cycle(1'b1, 1'b1, 3'd2, 16'hABCD, 2'b11, 1'b0, "be_wr_full");
    cycle(1'b1, 1'b1, 3'd2, 16'h1234, 2'b01, 1'b0, "be_wr_low");
    cycle(1'b1, 1'b1, 3'd2, 16'hFFFF, 2'b00, 1'b0, "be_wr_none");
    cycle(1'b1, 1'b0, 3'd2, 16'h0000, 2'b00, 1'b0, "be_rd");
    chk("be_merge_const", {16'h0, rdata_a}, 32'h0000AB34);

    // Out of range on the DEPTH=5 bank (addr 6 is legal for DEPTH=8).
    cycle(1'b1, 1'b1, 3'd6, 16'hFFFF, 2'b11, 1'b0, "oor_wr");
    chk("oor_wr_err_const", {31'h0, err_a}, 32'd1);
    cycle(1'b1, 1'b0, 3'd6, 16'h0000, 2'b00, 1'b0, "oor_rd");
    chk("oor_rd_data_const", {16'h0, rdata_a}, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 3'(i), 16'h0000, 2'b00, 1'b0, "oor_unchanged");

    // Clear sweep with a read held during busy.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 16'h5A5A, 2'b11, 1'b0, "fill");
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, "clr_start");
    busy_cnt = int'(busy_b);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 3'd3, 16'h0000, 2'b00, 1'b0, "clr_held_rd");
      busy_cnt += int'(busy_b);
    end
    chk("clr_busy_len_b", busy_cnt, 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'(i), 16'h0000, 2'b00, 1'b0, "clr_readback");

    // Collision of a read with clr, then a second clr while busy.
    cycle(1'b1, 1'b1, 3'd1, 16'h7777, 2'b11, 1'b0, "col_wr");
    cycle(1'b1, 1'b0, 3'd1, 16'h0000, 2'b00, 1'b1, "col_rd_clr");
    chk("col_rdata_const", {16'h0, rdata_b}, 32'h00007777);
    busy_cnt = int'(busy_b);
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, "col_clr_again");
    busy_cnt += int'(busy_b);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, "col_wait");
      busy_cnt += int'(busy_b);
    end
    chk("col_busy_len_b", busy_cnt, 32'd8);
    cycle(1'b1, 1'b0, 3'd1, 16'h0000, 2'b00, 1'b0, "col_rd_after");

    // Reset two cycles into a sweep.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 16'($urandom), 2'b11, 1'b0, "rst_fill");
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, "rst_clr");
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, "rst_sweep1");
    cycle(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, "rst_sweep2");
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_mid_sweep");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'(i), 16'h0000, 2'b00, 1'b0, "rst_readback");

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 29) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
